tetris_piece_ctrl: RTL

Sequences the active tetromino on the 10x20 playfield board.
- Spawns pieces from a pseudo-random generator.
- Converts key presses and gravity into one move per frame, gated by the board's per-move legality vector.
- Locks pieces, triggers the board's new-piece/line-clear path, and stalls while the board is busy.
- Sits between keyboard/frame-timing logic and the board plus the shape-expansion logic that turns anchor/rotation into four cell coordinates.

---
 rtl/tetris_piece_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_piece_ctrl.sv
// Active-tetromino sequencer: spawn, per-frame move/gravity arbitration, lock and game over.
// Optional held-key auto-repeat for left/right is enabled by defining TETRIS_AUTOREPEAT_EN.
module tetris_piece_ctrl #(
  parameter int unsigned GRAVITY_FRAMES = 48,
  parameter logic [4:0]  SPAWN_X        = 5'd3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned DAS_DELAY      = 16,
  parameter int unsigned DAS_RATE       = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk_rising_edge,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_rot_l,
  input  logic       key_rot_r,
  input  logic [4:0] can_move,
  input  logic       board_busy,
  output logic [2:0] piece,
  output logic [4:0] anchor_x,
  output logic [4:0] anchor_y,
  output logic [1:0] rot,
  output logic [4:0] prev_x,
  output logic [4:0] prev_y,
  output logic [1:0] prev_rot,
  output logic       get_new_block,
  output logic       game_over,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    ST_SPAWN     = 3'd0,
    ST_WAIT_BUSY = 3'd1,
    ST_FALL      = 3'd2,
    ST_LOCK      = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam logic [5:0] GRAV_TERM = 6'(GRAVITY_FRAMES - 1);

  state_t      state_q, state_d;
  logic [2:0]  piece_q, piece_d;
  logic [4:0]  x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [1:0]  rot_q, rot_d, prot_q, prot_d;
  logic        gnb_q, gnb_d, over_q, over_d;
  logic [5:0]  grav_q, grav_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  hist_q, hist_d;  // {left, right, rot_r, rot_l} at the previous frame edge
  logic [2:0]  lfsr_piece;
  logic        fire_l, fire_r, fire_rr, fire_rl, key_fired;
  logic        grav_term, drop_req, do_move;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lfsr_piece = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
  assign hist_d     = frame_clk_rising_edge ? {key_left, key_right, key_rot_r, key_rot_l} : hist_q;

  assign fire_rr   = key_rot_r & ~hist_q[1];
  assign fire_rl   = key_rot_l & ~hist_q[0];
  assign key_fired = fire_rr | fire_rl | fire_l | fire_r;
  assign grav_term = (grav_q == GRAV_TERM);
  assign drop_req  = grav_term | key_down;

`ifdef TETRIS_AUTOREPEAT_EN
  localparam logic [7:0] DAS_FIRST  = 8'(DAS_DELAY);
  localparam logic [7:0] DAS_RELOAD = 8'(DAS_DELAY - DAS_RATE + 1);

  // Counters hold "frames since the initial press"; a repeat reloads so the next one lands DAS_RATE later.
  logic [7:0] das_l_q, das_l_d, das_r_q, das_r_d;
  logic       rep_l, rep_r;

  assign rep_l  = key_left & hist_q[3] & (das_l_q == DAS_FIRST);
  assign rep_r  = key_right & hist_q[2] & (das_r_q == DAS_FIRST);
  assign fire_l = (key_left & ~hist_q[3]) | rep_l;
  assign fire_r = (key_right & ~hist_q[2]) | rep_r;

  always_comb begin
    das_l_d = das_l_q;
    das_r_d = das_r_q;
    if (frame_clk_rising_edge) begin
      if (!key_left)      das_l_d = '0;
      else if (!hist_q[3]) das_l_d = 8'd1;
      else if (rep_l)     das_l_d = DAS_RELOAD;
      else                das_l_d = das_l_q + 8'd1;
      if (!key_right)     das_r_d = '0;
      else if (!hist_q[2]) das_r_d = 8'd1;
      else if (rep_r)     das_r_d = DAS_RELOAD;
      else                das_r_d = das_r_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      das_l_q <= '0;
      das_r_q <= '0;
    end else begin
      das_l_q <= das_l_d;
      das_r_q <= das_r_d;
    end
  end
`else
  logic unused_das;
  assign unused_das = ^{DAS_DELAY, DAS_RATE};
  assign fire_l     = key_left & ~hist_q[3];
  assign fire_r     = key_right & ~hist_q[2];
`endif

  always_comb begin
    state_d = state_q;
    piece_d = piece_q;
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    px_d    = px_q;
    py_d    = py_q;
    prot_d  = prot_q;
    gnb_d   = 1'b0;
    over_d  = over_q;
    grav_d  = grav_q;
    do_move = 1'b0;

    case (state_q)
      ST_SPAWN: begin
        piece_d = lfsr_piece;
        x_d     = SPAWN_X;
        y_d     = '0;
        rot_d   = '0;
        px_d    = SPAWN_X;
        py_d    = '0;
        prot_d  = '0;
        gnb_d   = 1'b1;
        grav_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!board_busy) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (frame_clk_rising_edge) begin
          // A fired key is consumed even when illegal; it never falls through to a lower priority.
          if (fire_rr) begin
            if (can_move[2]) begin
              do_move = 1'b1;
              rot_d   = rot_q + 2'd1;
            end
          end else if (fire_rl) begin
            if (can_move[1]) begin
              do_move = 1'b1;
              rot_d   = rot_q - 2'd1;
            end
          end else if (fire_l) begin
            if (can_move[4]) begin
              do_move = 1'b1;
              x_d     = x_q - 5'd1;
            end
          end else if (fire_r) begin
            if (can_move[3]) begin
              do_move = 1'b1;
              x_d     = x_q + 5'd1;
            end
          end else if (drop_req) begin
            if (can_move[0]) begin
              do_move = 1'b1;
              y_d     = y_q + 5'd1;
            end else begin
              state_d = ST_LOCK;
            end
          end
          // A gravity tick pre-empted by a key stays pending at terminal count.
          if (grav_term) grav_d = key_fired ? grav_q : '0;
          else           grav_d = grav_q + 6'd1;
        end
      end
      ST_LOCK: begin
        if (y_q == '0) begin
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else begin
          state_d = ST_SPAWN;
        end
      end
      ST_OVER: ;
      default: state_d = ST_SPAWN;
    endcase

    if (do_move) begin
      px_d   = x_q;
      py_d   = y_q;
      prot_d = rot_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_SPAWN;
      piece_q <= '0;
      x_q     <= SPAWN_X;
      y_q     <= '0;
      rot_q   <= '0;
      px_q    <= SPAWN_X;
      py_q    <= '0;
      prot_q  <= '0;
      gnb_q   <= 1'b0;
      over_q  <= 1'b0;
      grav_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      piece_q <= piece_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rot_q   <= rot_d;
      px_q    <= px_d;
      py_q    <= py_d;
      prot_q  <= prot_d;
      gnb_q   <= gnb_d;
      over_q  <= over_d;
      grav_q  <= grav_d;
      lfsr_q  <= lfsr_d;
      hist_q  <= hist_d;
    end
  end

  assign piece         = piece_q;
  assign anchor_x      = x_q;
  assign anchor_y      = y_q;
  assign rot           = rot_q;
  assign prev_x        = px_q;
  assign prev_y        = py_q;
  assign prev_rot      = prot_q;
  assign get_new_block = gnb_q;
  assign game_over     = over_q;
  assign dbg_state_o   = state_q;

endmodule
